instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter: QDEPTH, 2, instruction queue depth in entries; legal values are 2 and 4.
REQ-003 clk  in  1  single clock; all state is updated on the rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 imem_req  out  1  request to instruction memory.
REQ-006 imem_addr  out  32  byte address of the request, always word-aligned.
REQ-007 imem_gnt  in  1  memory accepts the request in the cycle where imem_req and imem_gnt are both high.
REQ-008 imem_rvalid  in  1  read data valid; responses return in order, at least 1 cycle after the grant.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 redirect_valid  in  1  decode or execute requests a change of PC.
REQ-011 pc_source  in  2  redirect select: 00 = sequential, 01 = branch/J/JAL target, 10 = JR register, 11 = reserved.
REQ-012 branch_target  in  32  target used when pc_source = 01.
REQ-013 jr_target  in  32  target used when pc_source = 10.
REQ-014 if_valid  out  1  queue head is valid toward decode.
REQ-015 if_ready  in  1  decode accepts the head in the cycle where if_valid and if_ready are both high.
REQ-016 if_instr  out  32  head instruction word.
REQ-017 if_pc  out  32  byte address of the head instruction.
REQ-018 if_op  out  5  equals if_instr[31:27] (opcode to the control unit).
REQ-019 if_cond  out  2  equals if_instr[26:25]: 0 = always, 1 = if zero flag set, 2 = if zero flag clear.

Function
REQ-020 The FSM SHALL have three states: IDLE (no request outstanding), WAIT (one granted request outstanding), DISCARD (an outstanding response is stale).
REQ-021 At most one request SHALL be outstanding at any time.
REQ-022 imem_req SHALL be high in IDLE only when the queue has free space and redirect_valid is low.
REQ-023 imem_req and imem_addr SHALL hold stable until granted.
REQ-024 A grant in IDLE SHALL move the FSM to WAIT, and fetch_pc SHALL advance by 4 (32-bit wrap from 32'hFFFF_FFFC to 0).
REQ-025 An imem_rvalid in WAIT SHALL push {rdata, request address} into the queue and return the FSM to IDLE; a request may be issued in the same cycle if space remains.
REQ-026 The queue SHALL be a circular FIFO; push and pop in the same cycle keep the occupancy unchanged; a push is never attempted when the queue is full, because a request is only issued with space available.
REQ-027 A pop SHALL occur only on the if_valid/if_ready handshake; if_valid SHALL equal "queue not empty".
REQ-028 The if_* outputs SHALL come from queue registers only, with no combinational path from imem_rdata.
REQ-029 On redirect_valid, the unit SHALL flush the queue, load fetch_pc with the selected target, and suppress imem_req in that cycle.
REQ-029a Target selection: 01 = branch_target, 10 = jr_target, 00 = the current fetch_pc (flush only), 11 = treated as 00.
REQ-030 A redirect in WAIT with no rvalid in the same cycle SHALL move the FSM to DISCARD.
REQ-030a A redirect in WAIT coinciding with rvalid SHALL drop the response and move the FSM to IDLE.
REQ-031 In DISCARD, the next rvalid SHALL be dropped and the FSM SHALL return to IDLE; a further redirect in DISCARD only updates fetch_pc.
REQ-032 A redirect SHALL take priority over a push or pop in the same cycle; the popped instruction is still consumed by decode.
REQ-033 The first post-redirect request SHALL be issued no earlier than the cycle after the redirect; redirect-to-if_valid latency is 2 cycles plus the memory latency.
REQ-034 Targets whose bits [1:0] are nonzero SHALL be forced to word alignment (bits [1:0] cleared).

Reset
REQ-035 While rst_n is low at a clock edge, the unit SHALL load: FSM = IDLE, fetch_pc = RESET_PC, queue empty, imem_req = 0, if_valid = 0, and if_instr/if_pc/if_op/if_cond = 0.
REQ-036 Reset in WAIT or DISCARD SHALL abandon the outstanding response; a response arriving while rst_n is low, or in the first cycle after release before any new grant, SHALL be ignored.
REQ-037 The first imem_req SHALL assert in the first cycle after rst_n is sampled high.

Verification
REQ-038 Reset release, gnt = 1, 1-cycle latency, if_ready = 1 -> addresses 0, 4, 8 are issued; if_pc = 0, 4, 8 in order; if_op = rdata[31:27].
REQ-039 if_ready = 0 with QDEPTH = 2 -> exactly 2 instructions are buffered, imem_req stays low, and no instruction is lost when if_ready rises.
REQ-040 Redirect pc_source = 01, branch_target = 32'h100, issued while in WAIT -> the stale response is dropped, the next request address is 32'h100, and the queue is empty in the following cycle.
REQ-041 Redirect pc_source = 10, jr_target = 32'h203, coinciding with rvalid -> the response is dropped and the next imem_addr is 32'h200.
REQ-042 fetch_pc = 32'hFFFF_FFFC is granted -> the next address wraps to 32'h0000_0000.
REQ-043 rst_n is pulled low in WAIT, and rvalid arrives 1 cycle after release -> the response is ignored, if_valid stays 0, and a new request for RESET_PC is issued.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches to instruction memory
// with at most one request outstanding, buffers responses in a small circular
// queue and presents the head to decode. Redirects flush the queue, retarget
// the fetch PC and discard any response still in flight.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   imem_req/addr        fetch request and word-aligned byte address
//   imem_gnt             memory accepts the request (req & gnt)
//   imem_rvalid/rdata    in-order read response
//   redirect_valid       change-of-PC request from decode/execute
//   pc_source            01 branch_target, 10 jr_target, 00/11 flush only
//   branch_target        target for pc_source = 01
//   jr_target            target for pc_source = 10
//   if_valid/ready       handshake toward decode
//   if_instr/pc          head instruction and its byte address
//   if_op/if_cond        instruction fields [31:27] and [26:25]
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [1:0]  pc_source,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [4:0]  if_op,
    output logic [1:0]  if_cond
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_t        state, state_nxt;
    logic          run_q;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [31:0]   target;
    logic [31:0]   redirect_pc;
    entry_t        q [QDEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          push, pop, flush, grant;

    // Redirect target select; reserved and sequential codes keep the current PC
    always_comb begin
        target = fetch_pc;
        case (pc_source)
            2'b01:   target = branch_target;
            2'b10:   target = jr_target;
            default: target = fetch_pc;
        endcase
        redirect_pc = {target[31:2], 2'b00};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, request and queue control
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        grant     = 1'b0;
        push      = 1'b0;
        flush     = redirect_valid;
        pop       = (count != '0) && if_ready;
        case (state)
            IDLE: begin
                // run_q holds the first request off until reset has been released
                imem_req = run_q && !redirect_valid && (count < DEPTH);
                if (imem_req && imem_gnt) begin
                    grant     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push      = !redirect_valid;
                    state_nxt = IDLE;
                end else if (redirect_valid) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch PC, outstanding-request address and instruction queue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            fetch_pc <= {RESET_PC[31:2], 2'b00};
            req_pc   <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                q[i] <= '0;
            end
        end else begin
            run_q <= 1'b1;
            if (flush) begin
                fetch_pc <= redirect_pc;
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
            // A flush wins over push and pop; a popped head is still taken by decode
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    q[tail] <= '{instr: imem_rdata, pc: req_pc};
                    tail    <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign imem_addr = fetch_pc;
    assign if_valid  = (count != '0);
    assign if_instr  = q[head].instr;
    assign if_pc     = q[head].pc;
    assign if_op     = if_instr[31:27];
    assign if_cond   = if_instr[26:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [1:0]  pc_source;
    logic [31:0] branch_target;
    logic [31:0] jr_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  if_op;
    logic [1:0]  if_cond;

    int tests = 0;
    int fails = 0;

    // Instruction words with hand-decoded op/cond fields
    logic [31:0] dat      [3] = '{32'h0800_0000, 32'h8A00_0004, 32'hFC00_0008};
    logic [4:0]  exp_op   [3] = '{5'd1, 5'd17, 5'd31};
    logic [1:0]  exp_cond [3] = '{2'd0, 2'd1, 2'd2};
    logic [31:0] exp_addr [3] = '{32'h0, 32'h4, 32'h8};

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .pc_source(pc_source),
        .branch_target(branch_target), .jr_target(jr_target),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_op(if_op), .if_cond(if_cond)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; pc_source = 2'b00; branch_target = '0; jr_target = '0;
        if_ready = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    // One grant followed by a 1-cycle-latency response; starts and ends in IDLE
    task automatic fetch_one(input logic [31:0] d);
        imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = d; cyc(); imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        redirect_valid = 1'b0; pc_source = 2'b00; branch_target = '0; jr_target = '0; if_ready = 1'b0;
        cyc(); cyc(); settle();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", imem_req); end
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        tests++; if (if_instr !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h want 0", if_instr); end
        tests++; if (if_pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h want 0", if_pc); end
        tests++; if ({if_op, if_cond} !== 7'h0) begin fails++; $display("FAIL rst_opcond: got %h want 0", {if_op, if_cond}); end
        rst_n = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; settle();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req_presample: got %b want 0", imem_req); end
        cyc(); settle();
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rst_first_req: got %b want 1", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rst_first_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_sequential();
        do_reset();
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL seq_req%0d: got %b want 1", k, imem_req); end
            tests++; if (imem_addr !== exp_addr[k]) begin fails++; $display("FAIL seq_addr%0d: got %h want %h", k, imem_addr, exp_addr[k]); end
            if (k > 0) begin
                tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL seq_valid%0d: got %b want 1", k - 1, if_valid); end
                tests++; if (if_pc !== exp_addr[k-1]) begin fails++; $display("FAIL seq_pc%0d: got %h want %h", k - 1, if_pc, exp_addr[k-1]); end
                tests++; if (if_op !== exp_op[k-1]) begin fails++; $display("FAIL seq_op%0d: got %h want %h", k - 1, if_op, exp_op[k-1]); end
            end
            imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
            imem_rvalid = 1'b1; imem_rdata = dat[k]; settle();
            tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL seq_wait_req%0d: got %b want 0", k, imem_req); end
            cyc(); imem_rvalid = 1'b0;
        end
        settle();
        tests++; if (if_pc !== 32'h8) begin fails++; $display("FAIL seq_pc2: got %h want 8", if_pc); end
        tests++; if (if_instr !== dat[2]) begin fails++; $display("FAIL seq_instr2: got %h want %h", if_instr, dat[2]); end
        tests++; if (if_op !== exp_op[2]) begin fails++; $display("FAIL seq_op2: got %h want %h", if_op, exp_op[2]); end
        tests++; if (if_cond !== exp_cond[2]) begin fails++; $display("FAIL seq_cond2: got %h want %h", if_cond, exp_cond[2]); end
        if_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_one(dat[0]);
        fetch_one(dat[1]);
        imem_gnt = 1'b1; settle();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_full_req: got %b want 0", imem_req); end
        tests++; if (if_pc !== 32'h0) begin fails++; $display("FAIL bp_head_pc: got %h want 0", if_pc); end
        tests++; if (if_cond !== exp_cond[0]) begin fails++; $display("FAIL bp_head_cond: got %h want %h", if_cond, exp_cond[0]); end
        cyc(); cyc(); settle();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bp_hold_req: got %b want 0", imem_req); end
        tests++; if (imem_addr !== 32'h8) begin fails++; $display("FAIL bp_hold_addr: got %h want 8", imem_addr); end
        tests++; if (if_instr !== dat[0]) begin fails++; $display("FAIL bp_hold_instr: got %h want %h", if_instr, dat[0]); end
        imem_gnt = 1'b0; if_ready = 1'b1;
        cyc(); settle();
        tests++; if (if_pc !== 32'h4) begin fails++; $display("FAIL bp_second_pc: got %h want 4", if_pc); end
        tests++; if (if_instr !== dat[1]) begin fails++; $display("FAIL bp_second_instr: got %h want %h", if_instr, dat[1]); end
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL bp_space_req: got %b want 1", imem_req); end
        cyc(); settle();
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b want 0", if_valid); end
        if_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        do_reset();
        fetch_one(dat[0]);
        imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
        redirect_valid = 1'b1; pc_source = 2'b01; branch_target = 32'h100; settle();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rw_suppress: got %b want 0", imem_req); end
        cyc(); redirect_valid = 1'b0; pc_source = 2'b00; settle();
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rw_flush: got %b want 0", if_valid); end
        tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL rw_addr: got %h want 100", imem_addr); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rw_discard_req: got %b want 0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000; cyc(); imem_rvalid = 1'b0; settle();
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rw_stale_dropped: got %b want 0", if_valid); end
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rw_next_req: got %b want 1", imem_req); end
        tests++; if (imem_addr !== 32'h100) begin fails++; $display("FAIL rw_next_addr: got %h want 100", imem_addr); end
        fetch_one(dat[2]); settle();
        tests++; if (if_pc !== 32'h100) begin fails++; $display("FAIL rw_target_pc: got %h want 100", if_pc); end
        tests++; if (if_instr !== dat[2]) begin fails++; $display("FAIL rw_target_instr: got %h want %h", if_instr, dat[2]); end
    endtask

    task automatic test_discard_redirect();
        do_reset();
        imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
        redirect_valid = 1'b1; pc_source = 2'b01; branch_target = 32'h40; cyc();
        branch_target = 32'h300; cyc(); redirect_valid = 1'b0; settle();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL dr_still_discard: got %b want 0", imem_req); end
        tests++; if (imem_addr !== 32'h300) begin fails++; $display("FAIL dr_addr: got %h want 300", imem_addr); end
        imem_rvalid = 1'b1; imem_rdata = dat[1]; cyc(); imem_rvalid = 1'b0; settle();
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL dr_dropped: got %b want 0", if_valid); end
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL dr_idle_req: got %b want 1", imem_req); end
        redirect_valid = 1'b1; pc_source = 2'b00; branch_target = 32'h700; settle();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL dr_seq_suppress: got %b want 0", imem_req); end
        cyc(); redirect_valid = 1'b0; settle();
        tests++; if (imem_addr !== 32'h300) begin fails++; $display("FAIL dr_seq_keep: got %h want 300", imem_addr); end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = dat[0];
        redirect_valid = 1'b1; pc_source = 2'b10; jr_target = 32'h203;
        cyc(); imem_rvalid = 1'b0; redirect_valid = 1'b0; pc_source = 2'b00; settle();
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rr_dropped: got %b want 0", if_valid); end
        tests++; if (imem_addr !== 32'h200) begin fails++; $display("FAIL rr_aligned: got %h want 200", imem_addr); end
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rr_req: got %b want 1", imem_req); end
        redirect_valid = 1'b1; pc_source = 2'b11; branch_target = 32'h500; jr_target = 32'h600; settle();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rr_rsv_suppress: got %b want 0", imem_req); end
        cyc(); redirect_valid = 1'b0; pc_source = 2'b00; settle();
        tests++; if (imem_addr !== 32'h200) begin fails++; $display("FAIL rr_rsv_keep: got %h want 200", imem_addr); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1; pc_source = 2'b01; branch_target = 32'hFFFF_FFFC;
        cyc(); redirect_valid = 1'b0; pc_source = 2'b00; settle();
        tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_top: got %h want fffffffc", imem_addr); end
        imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0; settle();
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
        imem_rvalid = 1'b1; imem_rdata = dat[1]; cyc(); imem_rvalid = 1'b0; settle();
        tests++; if (if_pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc: got %h want fffffffc", if_pc); end
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL wrap_req: got %b want 1", imem_req); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        fetch_one(dat[1]);
        imem_gnt = 1'b1; cyc(); imem_gnt = 1'b0;
        rst_n = 1'b0; imem_rvalid = 1'b1; imem_rdata = dat[2]; cyc(); settle();
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rw_rst_valid: got %b want 0", if_valid); end
        tests++; if (if_instr !== 32'h0) begin fails++; $display("FAIL rw_rst_instr: got %h want 0", if_instr); end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rw_rst_req: got %b want 0", imem_req); end
        imem_rvalid = 1'b0; rst_n = 1'b1; cyc();
        imem_rvalid = 1'b1; imem_rdata = dat[2]; settle();
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rw_rel_req: got %b want 1", imem_req); end
        tests++; if (imem_addr !== 32'h0) begin fails++; $display("FAIL rw_rel_addr: got %h want 0", imem_addr); end
        cyc(); imem_rvalid = 1'b0; settle();
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rw_rel_ignored: got %b want 0", if_valid); end
        fetch_one(dat[0]); settle();
        tests++; if (if_pc !== 32'h0) begin fails++; $display("FAIL rw_refetch_pc: got %h want 0", if_pc); end
        tests++; if (if_instr !== dat[0]) begin fails++; $display("FAIL rw_refetch_instr: got %h want %h", if_instr, dat[0]); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_discard_redirect();
        test_redirect_rvalid();
        test_wrap();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
